// File: rtl/style_seq_pkg.sv
// Shared constants for the noninherited_flags write sequencer: state encoding,
// register width, field positions and named field codes for building masks.
package style_seq_pkg;

  localparam int unsigned NONINHERITED_W = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARB   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int unsigned DISPLAY_LSB    = 0;
  localparam int unsigned DISPLAY_W      = 5;
  localparam int unsigned STYLE_TYPE_LSB = 36;
  localparam int unsigned STYLE_TYPE_W   = 6;

  localparam logic [DISPLAY_W-1:0] DISPLAY_INLINE       = 5'd0;
  localparam logic [DISPLAY_W-1:0] DISPLAY_BLOCK        = 5'd1;
  localparam logic [DISPLAY_W-1:0] DISPLAY_LIST_ITEM    = 5'd2;
  localparam logic [DISPLAY_W-1:0] DISPLAY_INLINE_BLOCK = 5'd3;
  localparam logic [DISPLAY_W-1:0] DISPLAY_TABLE        = 5'd4;
  localparam logic [DISPLAY_W-1:0] DISPLAY_INLINE_TABLE = 5'd5;
  localparam logic [DISPLAY_W-1:0] DISPLAY_NONE         = 5'd16;

  localparam logic [STYLE_TYPE_W-1:0] NOPSEUDO = 6'd0;

  // Contiguous mask covering [lsb +: width] of the flag register.
  function automatic logic [NONINHERITED_W-1:0] field_mask(input int unsigned lsb,
                                                           input int unsigned width);
    logic [NONINHERITED_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < NONINHERITED_W; b++) begin
      if (b >= lsb && b < lsb + width) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [NONINHERITED_W-1:0] display_bits(input logic [DISPLAY_W-1:0] code);
    return NONINHERITED_W'(code) << DISPLAY_LSB;
  endfunction

  function automatic logic [NONINHERITED_W-1:0] style_type_bits(input logic [STYLE_TYPE_W-1:0] code);
    return NONINHERITED_W'(code) << STYLE_TYPE_LSB;
  endfunction

endpackage

// File: rtl/style_rr_arbiter.sv
// NREQ-way round-robin arbiter: one-hot grant to the first request at or after
// the pointer; the pointer moves just past the winner on every grant.
module style_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_grant,
  output logic            o_grant_vld
);

  localparam logic [IDX_W:0] NREQ_L = (IDX_W+1)'(NREQ);

  logic [IDX_W-1:0] r_ptr;
  logic [NREQ-1:0]  w_rot;
  logic             w_hit;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_nxt;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr_next;

  // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    w_rot = NREQ'({i_req, i_req} >> r_ptr);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_rot[k] && !w_hit) begin
        w_hit = 1'b1;
        w_off = IDX_W'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= NREQ_L) w_sum = w_sum - NREQ_L;
    w_idx = w_sum[IDX_W-1:0];
    w_nxt = {1'b0, w_idx} + (IDX_W+1)'(1);
    if (w_nxt == NREQ_L) w_nxt = '0;
    w_ptr_next = w_nxt[IDX_W-1:0];
    o_grant = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      o_grant[n] = w_hit && (w_idx == IDX_W'(n));
    end
    o_grant_vld = w_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/style_flag_sequencer.sv
// Serialises masked read-modify-writes from property handlers into one element's
// noninherited_flags register per resolve pass. Optional STYLE_SEQ_WATCHDOG_EN adds a stall watchdog.
module style_flag_sequencer
  import style_seq_pkg::*;
#(
  parameter int unsigned  NREQ          = 4,
  parameter int unsigned  W             = NONINHERITED_W,
  parameter logic [W-1:0] DEFAULT_FLAGS = '0
`ifdef STYLE_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned  TIMEOUT       = 64
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NREQ-1:0]   req_enable,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_mask,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      noninherited_flags
`ifdef STYLE_SEQ_WATCHDOG_EN
  ,
  output logic              timeout_err
`endif
);

  seq_state_e      r_state;
  seq_state_e      w_state_next;
  logic [W-1:0]    r_flags;
  logic [NREQ-1:0] r_finished;
  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_grant;
  logic            w_gvld;
  logic [NREQ-1:0] w_fin_next;
  logic [W-1:0]    w_mask;
  logic [W-1:0]    w_data;
  logic            w_wd_hit;

  assign w_cand = (r_state == ARB) ? (req_valid & ~r_finished) : '0;

  style_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk        (clk),
    .reset      (reset),
    .i_req      (w_cand),
    .o_grant    (w_grant),
    .o_grant_vld(w_gvld)
  );

  // Payload of the granted requester (grant is one-hot).
  always_comb begin
    w_mask = '0;
    w_data = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (w_grant[n]) begin
        w_mask = req_mask[n*W +: W];
        w_data = req_data[n*W +: W];
      end
    end
  end

  assign w_fin_next = r_finished | (w_grant & req_last);

`ifdef STYLE_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout_err;

  assign w_wd_hit = !w_gvld && (r_wd == WD_W'(TIMEOUT - 1));

  // Counts consecutive grant-less ARB cycles; expiry aborts the pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == CLEAR || w_gvld) begin
        r_wd <= '0;
      end else if (r_state == ARB) begin
        r_wd <= r_wd + 1'b1;
      end
      if (r_state == IDLE && start) begin
        r_timeout_err <= 1'b0;
      end else if (r_state == ARB && w_wd_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CLEAR;
      CLEAR:   w_state_next = (&r_finished) ? DONE : ARB;
      ARB:     if ((&w_fin_next) || w_wd_hit) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Read-modify-write datapath and per-requester completion tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags    <= DEFAULT_FLAGS;
      r_finished <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_finished <= ~req_enable;
      end else if (w_gvld) begin
        r_finished <= w_fin_next;
      end
      if (r_state == CLEAR) begin
        r_flags <= DEFAULT_FLAGS;
      end else if (w_gvld) begin
        r_flags <= (r_flags & ~w_mask) | (w_data & w_mask);
      end
    end
  end

  assign req_ready          = w_grant;
  assign busy               = (r_state != IDLE);
  assign done               = (r_state == DONE);
  assign noninherited_flags = r_flags;

endmodule

// File: tb/tb_style_flag_sequencer.sv
// Directed self-checking bench for style_flag_sequencer; watchdog scenario only
// when STYLE_SEQ_WATCHDOG_EN is defined.
module tb_style_flag_sequencer;
  import style_seq_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = NONINHERITED_W;

  logic              clk;
  logic              reset;
  logic              start;
  logic [NREQ-1:0]   req_enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_mask;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              busy;
  logic              done;
  logic [W-1:0]      flags;
`ifdef STYLE_SEQ_WATCHDOG_EN
  logic              timeout_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] disp_mask;

  style_flag_sequencer #(
    .NREQ(NREQ),
    .W(W),
    .DEFAULT_FLAGS('0)
`ifdef STYLE_SEQ_WATCHDOG_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .req_enable        (req_enable),
    .req_valid         (req_valid),
    .req_mask          (req_mask),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .busy              (busy),
    .done              (done),
    .noninherited_flags(flags)
`ifdef STYLE_SEQ_WATCHDOG_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] m,
                         input logic [W-1:0] d, input logic l);
    req_valid[i]      = v;
    req_mask[i*W +: W] = m;
    req_data[i*W +: W] = d;
    req_last[i]       = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_mask  = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", done); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    n_cmp++; if (flags !== 59'h0) begin n_bad++; $display("FAIL reset_flags: got %h exp 0", flags); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    req_enable = 4'b0001;
    set_req(0, 1'b1, 59'h1F, 59'h02, 1'b1);
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_idle_ready: got %b exp 0000", req_ready); end
    step();
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_clear: busy %b ready %b exp busy 1 ready 0000", busy, req_ready); end
    step();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b exp 0001", req_ready); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b exp 1", done); end
    n_cmp++; if (flags !== 59'h2) begin n_bad++; $display("FAIL single_flags: got %h exp 2", flags); end
    step();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: done %b busy %b exp 0 0", done, busy); end
    step();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    req_enable = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, W'(1) << (8 + i), W'(1) << (8 + i), 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 4'b0001 << k;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy || done !== 1'b0) begin n_bad++; $display("FAIL rr_grant%0d: ready %b done %b exp %b 0", k, req_ready, done, exp_rdy); end
      step();
    end
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rr_done: got %b exp 1", done); end
    n_cmp++; if (flags !== 59'hF00) begin n_bad++; $display("FAIL rr_flags: got %h exp f00", flags); end
    step();
  endtask

  task automatic test_overlap();
    req_enable = 4'b1010;
    clear_reqs();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (flags !== 59'hF00) begin n_bad++; $display("FAIL ovl_hold: got %h exp f00", flags); end
    step();
    set_req(1, 1'b1, disp_mask, ~disp_mask | display_bits(DISPLAY_BLOCK), 1'b1);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL ovl_grant1: got %b exp 0010", req_ready); end
    n_cmp++; if (flags !== 59'h0) begin n_bad++; $display("FAIL ovl_cleared: got %h exp 0", flags); end
    step();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL ovl_finished_req: got %b exp 0000", req_ready); end
    n_cmp++; if (flags !== 59'h1) begin n_bad++; $display("FAIL ovl_masked: got %h exp 1", flags); end
    step();
    set_req(3, 1'b1, disp_mask, display_bits(DISPLAY_TABLE), 1'b1);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL ovl_grant3: got %b exp 1000", req_ready); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || flags !== 59'h4) begin n_bad++; $display("FAIL ovl_final: done %b flags %h exp 1 4", done, flags); end
    step();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    req_enable = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    set_req(0, 1'b1, 59'h0, 59'h0, 1'b0);
    set_req(2, 1'b1, 59'h0, 59'h0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy || done !== 1'b0) begin n_bad++; $display("FAIL fair_grant%0d: ready %b done %b exp %b 0", k, req_ready, done, exp_rdy); end
      step();
    end
    do_reset();
  endtask

  task automatic test_start_busy();
    req_enable = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    req_enable = 4'b0000;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL sb_arb: ready %b busy %b exp 0000 1", req_ready, busy); end
    step();
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL sb_ignored: done %b busy %b exp 0 1", done, busy); end
    step();
    set_req(0, 1'b1, 59'h1F << 40, 59'h15 << 40, 1'b1);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL sb_grant: got %b exp 0001", req_ready); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || flags !== (59'h15 << 40)) begin n_bad++; $display("FAIL sb_done: done %b flags %h exp 1 %h", done, flags, 59'h15 << 40); end
    step();
  endtask

  task automatic test_reset_mid();
    req_enable = 4'b0011;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    set_req(0, 1'b1, 59'hFF, 59'hAA, 1'b0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rm_grant: got %b exp 0001", req_ready); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (flags !== 59'hAA || busy !== 1'b1) begin n_bad++; $display("FAIL rm_pre: flags %h busy %b exp aa 1", flags, busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || flags !== 59'h0 || done !== 1'b0) begin n_bad++; $display("FAIL rm_after: busy %b flags %h done %b exp 0 0 0", busy, flags, done); end
    step();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_nodone: done %b busy %b exp 0 0", done, busy); end
    step();
  endtask

  task automatic test_no_enable();
    req_enable = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ne_clear: busy %b done %b exp 1 0", busy, done); end
    step();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ne_done: got %b exp 1", done); end
    step();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ne_idle: done %b busy %b exp 0 0", done, busy); end
    step();
  endtask

  task automatic test_back_to_back();
    req_enable = 4'b0100;
    set_req(2, 1'b1, disp_mask, display_bits(DISPLAY_INLINE_BLOCK), 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL b2b_grant_a: got %b exp 0100", req_ready); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || flags !== 59'h3) begin n_bad++; $display("FAIL b2b_done_a: done %b flags %h exp 1 3", done, flags); end
    step();
    req_enable = 4'b0001;
    set_req(0, 1'b1, 59'h0, {W{1'b1}}, 1'b1);
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (flags !== 59'h3 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: flags %h busy %b exp 3 0", flags, busy); end
    step();
    start = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001 || flags !== 59'h0) begin n_bad++; $display("FAIL b2b_grant_b: ready %b flags %h exp 0001 0", req_ready, flags); end
    step();
    clear_reqs();
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || flags !== 59'h0) begin n_bad++; $display("FAIL b2b_zero_mask: done %b flags %h exp 1 0", done, flags); end
    step();
  endtask

`ifdef STYLE_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    req_enable = 4'b0001;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL wd_wait%0d: done %b err %b exp 0 0", k, done, timeout_err); end
      step();
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL wd_fire: done %b err %b exp 1 1", done, timeout_err); end
    step();
    req_enable = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL wd_hold: err %b busy %b exp 1 0", timeout_err, busy); end
    step();
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wd_clear: got %b exp 0", timeout_err); end
    step();
    step();
    step();
  endtask
`endif

  initial begin
    disp_mask  = field_mask(DISPLAY_LSB, DISPLAY_W);
    reset      = 1'b1;
    start      = 1'b0;
    req_enable = '0;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_overlap();
    test_fairness();
    test_start_busy();
    test_reset_mid();
    test_no_enable();
    test_back_to_back();
`ifdef STYLE_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/style_flag_sequencer.md
Name: style_flag_sequencer

Overview:
Sequences all property-handler writes to one element's noninherited_flags register during a style-resolve pass.
- Property handlers (display, position, float, ...) are requesters; the register is the shared resource.
- Each write is a masked read-modify-write; grants are round-robin, one write per cycle.
- Sits between the per-property apply logic and the RenderStyle flag storage; signals the resolver when every handler has finished.

Parameters:
NREQ, 4, number of property-handler requesters
W, 59, width of noninherited_flags
DEFAULT_FLAGS, 59'h0, value loaded into the register at the start of each pass
TIMEOUT, 64, watchdog limit in cycles (used only with STYLE_SEQ_WATCHDOG_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse: begin a resolve pass for a new element
req_enable  input  NREQ  per-requester participation, sampled on the accepted start
req_valid  input  NREQ  requester i has a write pending
req_mask  input  NREQ*W  slice i = bit mask of fields requester i writes
req_data  input  NREQ*W  slice i = new field values (only masked bits used)
req_last  input  NREQ  this write is requester i's final write of the pass
req_ready  output  NREQ  one-hot grant; write i accepted when valid & ready
busy  output  1  pass in progress (any state other than IDLE)
done  output  1  1-cycle pulse at end of pass
noninherited_flags  output  W  flag register
timeout_err  output  1  watchdog abort flag (STYLE_SEQ_WATCHDOG_EN only)

Behaviour:
Reset values:
- state=IDLE; noninherited_flags=DEFAULT_FLAGS.
- req_ready=0, busy=0, done=0; finished=0; RR pointer=0.

State IDLE:
- start=1 → CLEAR; latch finished = ~req_enable.
- req_ready=0; req_valid ignored.

State CLEAR (1 cycle):
- noninherited_flags <= DEFAULT_FLAGS.
- If finished is all-ones → DONE, else → ARB.

State ARB:
- Candidates = req_valid & ~finished.
- Grant the first candidate at or after the RR pointer, wrapping modulo NREQ.
- req_ready is combinational from the current state and inputs, so a grant is given the same cycle valid is seen.
- On a grant to i:
  - flags <= (flags & ~mask_i) | (data_i & mask_i).
  - Pointer <= (i+1) mod NREQ.
  - If req_last[i], set finished[i].
- When finished (including the bit set this edge) is all-ones → DONE on that edge.
- No candidates: hold state and flags.

State DONE:
- done=1 for one cycle, then → IDLE.
- Flags hold until the next pass's CLEAR.

Boundary conditions:
- start while busy: ignored.
- Requester with nothing to write: sends mask=0 with last=1.
- Zero mask: legal; register unchanged.
- Overlapping masks from different requesters: later grant wins.
- Valid from an already-finished requester: never granted; ready stays 0.
- reset mid-pass: back to IDLE with reset values on the next edge; no done pulse.
- Latency: start→first possible grant = 2 cycles (IDLE→CLEAR→ARB). Final grant → done = next cycle.

Optional Feature:
STYLE_SEQ_WATCHDOG_EN
- Defined:
  - Counter clears on every grant and on CLEAR; increments each ARB cycle with no grant.
  - On reaching TIMEOUT: → DONE, timeout_err <= 1.
  - timeout_err stays 1 until the next accepted start or reset.
- Undefined: no counter, and the timeout_err port is absent; ARB waits indefinitely.

Decomposition:
Package style_seq_pkg holds:
- NONINHERITED_W=59.
- State encoding: IDLE, CLEAR, ARB, DONE.
- Field positions: DISPLAY [4:0], STYLE_TYPE [41:36].
- Display codes and the NOPSEUDO code, so requesters build masks from named constants.

One sub-module: style_rr_arbiter (NREQ-way round-robin, one-hot grant, pointer register). The FSM and RMW datapath stay in the top module.

Test Plan:
- Single write: NREQ=4, req_enable=4'b0001, start; req0 mask=0x1F, data=0x02, last=1 → ready[0] on cycle 2; flags[4:0]=2; done pulse cycle 3.
- Round-robin: all 4 enabled, all valid with last=1 → grants 0,1,2,3 on consecutive cycles; done on the cycle after the 4th grant.
- Fairness: req0 valid with last=0 every cycle, req2 valid → grants alternate 0,2,0,2; req1 and req3 never granted.
- Overlap: req1 writes DISPLAY=1, then req3 writes DISPLAY=4 → final flags[4:0]=4; other bits stay DEFAULT_FLAGS.
- Edge cases:
  - start while busy: no effect.
  - reset asserted mid-ARB → next cycle: busy=0, flags=DEFAULT_FLAGS, no done.
  - req_enable=0 → done 2 cycles after start.
- Watchdog: with STYLE_SEQ_WATCHDOG_EN, TIMEOUT=8, one enabled requester never valid → done + timeout_err after 8 idle ARB cycles; the next start clears timeout_err.
